gray_conv_pipe: RTL and testbench
=================================

// Module: gray_conv_pipe
// PURPOSE
//  Streaming, parametrised Gray<->binary converter. Direction is selected per beat.
//  The conversion is spread over STAGES register stages, with valid/ready flow control.
//  An optional monitor checks that successive gray-mode inputs change by exactly one bit.
//  Sits between a Gray-coded position/pointer source and binary arithmetic consumers.
// PARAMETERS
//  WIDTH     8   data width in bits, 2..32
//  STAGES    2   pipeline depth (= latency), 1..WIDTH
//  CHECK_EN  1   1: Gray sequence monitor present; 0: out_err/err_cnt tied to 0
//  CNT_W     8   width of the saturating error counter
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous reset, active low
//  in_valid   in   1       input beat valid
//  in_ready   out  1       input beat accepted when in_valid && in_ready
//  in_data    in   WIDTH   code to convert
//  in_dir     in   1       0: gray->binary, 1: binary->gray
//  out_valid  out  1       output beat valid
//  out_ready  in   1       downstream accepts when out_valid && out_ready
//  out_data   out  WIDTH   converted code
//  out_dir    out  1       in_dir carried with the beat
//  out_err    out  1       this beat violated the one-bit-change rule (gray->binary only)
//  err_cnt    out  CNT_W   saturating count of violations
//  err_clr    in   1       synchronous clear of err_cnt and the monitor history
// BEHAVIOUR
//  Reset (async, rst_n=0): all stage valids, out_valid, out_data, out_dir, out_err and err_cnt = 0.
//   Monitor history is marked empty. in_ready = 1 one cycle after rst_n deasserts.
//   Reset asserted mid-stream drops all in-flight beats; no partial output.
//  Conversion:
//   bin->gray: g = b ^ (b>>1).
//   gray->bin: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i] (prefix XOR from the MSB).
//   Split into chunks of CH = ceil(WIDTH/STAGES) bits, MSB first.
//   Stage s finalises its chunk and passes the running MSB-side bit to the next stage.
//   bin->gray beats are finished in stage 0 and ride the remaining stages unchanged.
//  Latency: exactly STAGES cycles from acceptance to out_valid when not stalled.
//   Throughput: 1 beat/cycle.
//  Flow control: each stage holds a valid bit.
//   Stage k loads when it is empty, or when it is drained into stage k+1/output that same cycle.
//   in_ready = stage 0 can load. No combinational path from in_valid to in_ready.
//   Capacity = STAGES beats.
//   While out_valid && !out_ready, out_data, out_dir and out_err are held stable.
//  Monitor (CHECK_EN=1): evaluated at acceptance of in_dir=0 beats only.
//   d = in_data ^ last_gray. Violation = history valid && popcount(d) != 1.
//   A repeated code (d = 0) is a violation.
//   last_gray <= in_data and history valid <= 1 on every accepted gray beat.
//   in_dir=1 beats do not touch the history.
//   The violation flag travels with its beat to out_err.
//   err_cnt increments at acceptance and saturates at 2^CNT_W-1.
//   err_clr: history is emptied and err_cnt <= 0.
//   If err_clr and an accepted gray beat coincide: the beat is not checked (history was empty);
//   it still loads the history, and err_cnt = 0.
//  Wrap-around: gray(2^WIDTH-1) -> gray(0) differs in one bit (MSB); no violation.
// STRUCTURE
//  Package gray_pkg: DIR_G2B/DIR_B2G constants; functions bin2gray(), gray2bin_chunk(), popcount().
//  Sub-module gray_seq_monitor: history register, violation detect, saturating err_cnt.
//  Pipeline and handshake are in gray_conv_pipe.
// TESTING (WIDTH=8, STAGES=2, CNT_W=8, out_ready=1 unless stated)
//  1 Reset: rst_n=0 mid-stream with 2 beats in flight
//    -> out_valid=0 and err_cnt=0 immediately; nothing emerges after release.
//  2 Convert: gray 0x0C dir0 -> out 0x08 two cycles later;
//    bin 0xFF dir1 -> 0x80; gray 0x80 -> 0xFF; all 256 codes round-trip.
//  3 Sequence: gray 00,01,03,02,07 -> out_err 0,0,0,0,1 and err_cnt=1;
//    then 07,07 -> out_err=1 on the repeat, err_cnt=2.
//  4 Wrap and clear: gray 0x80 then 0x00 -> no error.
//    Pulse err_clr together with beat 0x55 -> err_cnt=0 and beat 0x55 out_err=0.
//    The next beat 0x54 -> out_err=0.
//  5 Backpressure: out_ready=0, offer 4 back-to-back beats
//    -> 2 accepted, in_ready=0, out_data held.
//    Raise out_ready -> 4 beats out in order, no loss or duplication.
//  6 Saturation: 300 consecutive violations -> err_cnt sticks at 0xFF.
//    Interleaved dir1 beats leave the history unchanged.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray/binary conversion pipeline.
//  DIR_G2B / DIR_B2G : per-beat direction codes
//  bin2gray()        : full binary->Gray conversion (operates on MAX_W bits)
//  gray2bin_chunk()  : finalises bits [hi:lo] of a partly converted Gray word
//  popcount()        : number of set bits, used by the sequence monitor
package gray_pkg;

    localparam logic DIR_G2B = 1'b0;
    localparam logic DIR_B2G = 1'b1;
    localparam int   MAX_W   = 32;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Bits above hi are already binary, bits [hi:lo] are still Gray, bits below
    // lo are left untouched. The running bit starts as bit hi+1 (zero above the
    // data width, which makes the MSB copy straight through).
    function automatic logic [MAX_W-1:0] gray2bin_chunk(input logic [MAX_W-1:0] w,
                                                        input int hi,
                                                        input int lo);
        logic [MAX_W-1:0] r;
        logic             run;
        r   = w;
        run = 1'b0;
        for (int i = MAX_W - 1; i >= 0; i--) begin
            if (i > hi) begin
                run = w[i];
            end else if (i >= lo) begin
                r[i] = run ^ w[i];
                run  = r[i];
            end else begin
                r[i] = w[i];
            end
        end
        return r;
    endfunction

    function automatic logic [5:0] popcount(input logic [MAX_W-1:0] v);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < MAX_W; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/gray_seq_monitor.sv
// Gray sequence monitor: remembers the last accepted Gray-mode code and flags
// any accepted Gray beat that does not differ from it in exactly one bit.
//  clk, rst_n  : clock, async active-low reset
//  acc_i       : a Gray-mode (gray->binary) beat is accepted this cycle
//  data_i      : the accepted code
//  clr_i       : empties the history and zeroes the counter
//  viol_o      : combinational violation flag for the beat being accepted
//  err_cnt_o   : registered saturating violation count
module gray_seq_monitor
    import gray_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             acc_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             clr_i,
    output logic             viol_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             hist_vld_q, hist_vld_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             viol_s;

    // Violation detect, history update and saturating count
    always_comb begin
        viol_s     = 1'b0;
        hist_vld_d = hist_vld_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        // A clear coinciding with a beat means the history counts as empty.
        if (acc_i && hist_vld_q && !clr_i) begin
            viol_s = (popcount(MAX_W'(data_i ^ last_q)) != 6'd1);
        end else begin
            viol_s = 1'b0;
        end
        if (acc_i) begin
            hist_vld_d = 1'b1;
            last_d     = data_i;
        end else if (clr_i) begin
            hist_vld_d = 1'b0;
        end else begin
            hist_vld_d = hist_vld_q;
        end
        if (clr_i) begin
            cnt_d = '0;
        end else if (viol_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Monitor state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_vld_q <= 1'b0;
            last_q     <= '0;
            cnt_q      <= '0;
        end else begin
            hist_vld_q <= hist_vld_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
        end
    end

    assign viol_o    = viol_s;
    assign err_cnt_o = cnt_q;

endmodule

// File: rtl/gray_conv_pipe.sv
// Streaming Gray<->binary converter with STAGES register stages and
// valid/ready flow control. Gray->binary beats are resolved one MSB-first
// chunk per stage; binary->Gray beats are finished in stage 0.
//  clk, rst_n           : clock, async active-low reset
//  in_valid/in_ready    : input handshake; in_data code, in_dir direction
//  out_valid/out_ready  : output handshake; out_data, out_dir, out_err
//  err_cnt, err_clr     : saturating violation count and its clear
module gray_conv_pipe
    import gray_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int STAGES   = 2,
    parameter int CHECK_EN = 1,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_dir,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             err_clr
);

    localparam int CH = (WIDTH + STAGES - 1) / STAGES;

    logic              init_q;
    logic [STAGES-1:0] vld_q, dir_q, err_q;
    logic [WIDTH-1:0]  dat_q [STAGES];
    logic [STAGES-1:0] rdy_s;
    logic [STAGES-1:0] up_vld_s, up_dir_s, up_err_s;
    logic [WIDTH-1:0]  dat_d [STAGES];
    logic              acc_s, viol_s;

    // Ready chain: a stage can load when empty or when it drains this cycle
    always_comb begin
        logic run;
        rdy_s = '0;
        run   = out_ready;
        for (int s = STAGES - 1; s >= 0; s--) begin
            run      = !vld_q[s] || run;
            rdy_s[s] = run;
        end
    end

    // init_q keeps in_ready low until the first edge after reset release.
    assign in_ready = init_q && rdy_s[0];
    assign acc_s    = in_valid && in_ready;

    // Upstream beat and next data for every stage
    always_comb begin
        int hi;
        int lo;
        hi       = 0;
        lo       = 0;
        up_vld_s = '0;
        up_dir_s = '0;
        up_err_s = '0;
        for (int s = 0; s < STAGES; s++) begin
            dat_d[s] = '0;
        end
        up_vld_s[0] = acc_s;
        up_dir_s[0] = in_dir;
        up_err_s[0] = viol_s && (in_dir == DIR_G2B);
        lo          = (WIDTH - CH > 0) ? (WIDTH - CH) : 0;
        if (in_dir == DIR_B2G) begin
            dat_d[0] = WIDTH'(bin2gray(MAX_W'(in_data)));
        end else begin
            dat_d[0] = WIDTH'(gray2bin_chunk(MAX_W'(in_data), WIDTH - 1, lo));
        end
        for (int s = 1; s < STAGES; s++) begin
            up_vld_s[s] = vld_q[s-1];
            up_dir_s[s] = dir_q[s-1];
            up_err_s[s] = err_q[s-1];
            // A chunk past bit 0 (hi < lo) leaves the word unchanged.
            hi = WIDTH - 1 - s * CH;
            lo = (hi - CH + 1 > 0) ? (hi - CH + 1) : 0;
            if (dir_q[s-1] == DIR_B2G) begin
                dat_d[s] = dat_q[s-1];
            end else begin
                dat_d[s] = WIDTH'(gray2bin_chunk(MAX_W'(dat_q[s-1]), hi, lo));
            end
        end
    end

    // Pipeline stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q <= 1'b0;
            vld_q  <= '0;
            dir_q  <= '0;
            err_q  <= '0;
            for (int s = 0; s < STAGES; s++) begin
                dat_q[s] <= '0;
            end
        end else begin
            init_q <= 1'b1;
            for (int s = 0; s < STAGES; s++) begin
                if (rdy_s[s]) begin
                    vld_q[s] <= up_vld_s[s];
                    if (up_vld_s[s]) begin
                        dat_q[s] <= dat_d[s];
                        dir_q[s] <= up_dir_s[s];
                        err_q[s] <= up_err_s[s];
                    end
                end
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_data  = dat_q[STAGES-1];
    assign out_dir   = dir_q[STAGES-1];
    assign out_err   = err_q[STAGES-1];

    generate
        if (CHECK_EN != 0) begin : g_mon
            gray_seq_monitor #(
                .WIDTH (WIDTH),
                .CNT_W (CNT_W)
            ) u_mon (
                .clk       (clk),
                .rst_n     (rst_n),
                .acc_i     (acc_s && (in_dir == DIR_G2B)),
                .data_i    (in_data),
                .clr_i     (err_clr),
                .viol_o    (viol_s),
                .err_cnt_o (err_cnt)
            );
        end else begin : g_nomon
            assign viol_s  = 1'b0;
            assign err_cnt = '0;
        end
    endgenerate

endmodule

// File: tb/tb_gray_conv_pipe.sv
// Self-checking bench for gray_conv_pipe (WIDTH=8, STAGES=2, CNT_W=8).
// Expected beats are queued at acceptance and compared when they emerge.
module tb_gray_conv_pipe;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       in_valid  = 1'b0;
    logic       in_ready;
    logic [7:0] in_data   = 8'h00;
    logic       in_dir    = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_dir;
    logic       out_err;
    logic [7:0] err_cnt;
    logic       err_clr   = 1'b0;

    typedef struct packed {
        logic [7:0] d;
        logic       dir;
        logic       err;
    } exp_t;

    typedef struct {
        logic [7:0] din;
        logic       dir;
        logic [7:0] exp_d;
        logic       exp_err;
        logic       clr;
        logic       cnt_chk;
        logic [7:0] exp_cnt;
    } vec_t;

    exp_t sb[$];
    exp_t e_pop;
    vec_t vecs[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   n_acc    = 0;
    int   base;

    gray_conv_pipe #(
        .WIDTH    (8),
        .STAGES   (2),
        .CHECK_EN (1),
        .CNT_W    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_dir   (out_dir),
        .out_err   (out_err),
        .err_cnt   (err_cnt),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] b2g(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    // Offer one beat; queue its expectation when the handshake is seen.
    task automatic send(input logic [7:0] d, input logic dir, input logic [7:0] ed,
                        input logic ee, input logic clr);
        int  n;
        bit  ok;
        in_valid = 1'b1;
        in_data  = d;
        in_dir   = dir;
        err_clr  = clr;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else n++;
        end
        if (ok) begin
            sb.push_back('{d: ed, dir: dir, err: ee});
            n_acc++;
        end else begin
            chk_cnt++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic drain(input int target);
        int n;
        n = 0;
        while ((sb.size() != 0 || n_acc < target) && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (n >= 300) begin
            chk_cnt++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare every beat leaving the DUT
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_beat: got %0h expected no beat", out_data);
            end else begin
                e_pop = sb.pop_front();
                check("beat", {23'd0, out_data, out_dir, out_err},
                      {23'd0, e_pop.d, e_pop.dir, e_pop.err});
            end
        end
    end

    initial begin
        // din, dir, exp_d, exp_err, clr, cnt_chk, exp_cnt
        vecs.push_back('{8'h0C, 1'b0, 8'h08, 1'b0, 1'b1, 1'b1, 8'h00});
        vecs.push_back('{8'hFF, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{8'h80, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 8'h01});
        vecs.push_back('{8'h0C, 1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{8'h0A, 1'b0, 8'h0C, 1'b0, 1'b1, 1'b1, 8'h00});
        vecs.push_back('{8'h55, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{8'h7F, 1'b0, 8'h55, 1'b1, 1'b0, 1'b1, 8'h01});
        vecs.push_back('{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00});
        vecs.push_back('{8'h01, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{8'h07, 1'b0, 8'h05, 1'b1, 1'b0, 1'b1, 8'h01});
        vecs.push_back('{8'h07, 1'b0, 8'h05, 1'b1, 1'b0, 1'b1, 8'h02});
        vecs.push_back('{8'h80, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h03});
        vecs.push_back('{8'h55, 1'b0, 8'h66, 1'b0, 1'b1, 1'b1, 8'h00});
        vecs.push_back('{8'h54, 1'b0, 8'h67, 1'b0, 1'b0, 1'b1, 8'h00});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Latency: out_valid rises on the second edge after the input beat
        send(8'h3C, 1'b1, 8'h22, 1'b0, 1'b0);
        check("lat_early", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("lat_out", {31'd0, out_valid}, 32'd1);
        drain(n_acc);

        // Conversion, sequence, wrap and clear vectors
        foreach (vecs[k]) begin
            send(vecs[k].din, vecs[k].dir, vecs[k].exp_d, vecs[k].exp_err, vecs[k].clr);
            if (vecs[k].cnt_chk) check("vec_err_cnt", {24'd0, err_cnt}, {24'd0, vecs[k].exp_cnt});
        end
        drain(n_acc);

        // Round trip of every code; consecutive Gray codes never violate
        for (int i = 0; i < 256; i++) begin
            send(8'(i), 1'b1, b2g(8'(i)), 1'b0, 1'b0);
            send(b2g(8'(i)), 1'b0, 8'(i), 1'b0, (i == 0));
        end
        drain(n_acc);
        check("roundtrip_err_cnt", {24'd0, err_cnt}, 32'd0);

        // Backpressure: capacity two, output held, then in-order release
        base      = n_acc;
        out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++) send(8'(8'hA1 + k), 1'b1, b2g(8'(8'hA1 + k)), 1'b0, 1'b0);
            end
        join_none
        repeat (5) @(posedge clk);
        #1;
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_accepted", n_acc - base, 32'd2);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        check("bp_out_data", {24'd0, out_data}, 32'hF1);
        repeat (3) @(posedge clk);
        #1;
        check("bp_out_data_held", {24'd0, out_data}, 32'hF1);
        out_ready = 1'b1;
        drain(base + 4);

        // Saturation with interleaved binary beats one bit away from the history
        for (int i = 0; i <= 300; i++) begin
            send(8'h33, 1'b0, 8'h22, (i != 0), (i == 0));
            if (i % 4 == 0) send(8'h32, 1'b1, 8'h2B, 1'b0, 1'b0);
            if (i == 100) check("sat_cnt_100", {24'd0, err_cnt}, 32'd100);
        end
        drain(n_acc);
        check("sat_cnt_max", {24'd0, err_cnt}, 32'hFF);

        // Reset with two beats in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_dir    = 1'b1;
        in_data   = 8'h11;
        @(posedge clk);
        #1;
        in_data = 8'h22;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("inflight_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_err_cnt", {24'd0, err_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_no_output", {31'd0, out_valid}, 32'd0);
        // History emptied by reset: 0x00 after 0x33 is not checked
        send(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        check("post_rst_hist_cnt", {24'd0, err_cnt}, 32'd0);
        drain(n_acc);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
